// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MDU_MADD_EN to make op=4 (MADD, signed multiply-accumulate) legal.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic { IDLE, RUN } state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;

  logic          legal;
  logic          launch_div;
  logic [63:0]   a_sx, b_sx;
  logic [63:0]   prod_s, prod_u;
  logic          neg_a, neg_b;
  logic [31:0]   mag_a, mag_b, dvsr;
  logic [31:0]   uq, ur, quo, rem;
  logic [31:0]   res_hi_d, res_lo_d;
  logic          wr_d;

`ifdef MDU_MADD_EN
  logic [63:0]   acc;
  assign legal = (op <= 3'd4);
  assign acc   = {hi_q, lo_q} + prod_s;
`else
  assign legal = (op <= 3'd3);
`endif

  assign launch_div = (op[2:1] == 2'b01);

  // Low 64 bits of the sign-extended product equal the signed product.
  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: sidesteps the MIN/-1 overflow case.
  assign neg_a = (op_q == 3'd2) && a_q[31];
  assign neg_b = (op_q == 3'd2) && b_q[31];
  assign mag_a = neg_a ? (32'd0 - a_q) : a_q;
  assign mag_b = neg_b ? (32'd0 - b_q) : b_q;
  assign dvsr  = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign uq    = mag_a / dvsr;
  assign ur    = mag_a % dvsr;
  assign quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign rem   = neg_a ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    wr_d     = 1'b1;
    unique case (op_q)
      3'd0: {res_hi_d, res_lo_d} = prod_s;
      3'd1: {res_hi_d, res_lo_d} = prod_u;
      3'd2, 3'd3: begin
        res_hi_d = rem;
        res_lo_d = quo;
        wr_d     = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      3'd4: {res_hi_d, res_lo_d} = acc;
`endif
      default: wr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= A;
          if (lo_we) lo_q <= A;
          if (start && legal) begin
            op_q    <= op;
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= launch_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            if (wr_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed literal checks plus randomized run against a
// cycle-numbered behavioural model of md_unit.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: an op launched at cycle N completes at cycle N+lat.
  longint      cyc = 0;
  longint      m_done = 0;
  bit          m_valid = 0;
  bit          m_busy = 0;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [31:0] m_hi = 0, m_lo = 0;

  function automatic bit legal_op(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return o <= 3'd4;
`else
    return o <= 3'd3;
`endif
  endfunction

  task automatic model_complete();
    longint sp;
    logic [63:0] up;
    int sa, sb;
    sa = $signed(m_a);
    sb = $signed(m_b);
    sp = longint'(sa) * longint'(sb);
    case (m_op)
      3'd0: {m_hi, m_lo} = sp;
      3'd1: begin
        up = {32'd0, m_a} * {32'd0, m_b};
        {m_hi, m_lo} = up;
      end
      3'd2: if (m_b != 0) begin
        if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          m_lo = sa / sb;
          m_hi = sa % sb;
        end
      end
      3'd3: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
      3'd4: {m_hi, m_lo} = {m_hi, m_lo} + sp;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_hi    = 0;
      m_lo    = 0;
    end else if (m_busy) begin
      if (cyc == m_done) begin
        model_complete();
        m_busy = 0;
      end
    end else begin
      if (hi_we) m_hi = A;
      if (lo_we) m_lo = A;
      if (start && legal_op(op)) begin
        m_busy = 1;
        m_op   = op;
        m_a    = A;
        m_b    = B;
        m_done = cyc + ((op == 3'd2 || op == 3'd3) ? DC : MC);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("HI", 64'(HI), 64'(m_hi));
      chk("LO", 64'(LO), 64'(m_lo));
    end
  end

  task automatic mt(input logic [31:0] h, input logic [31:0] l);
    hi_we = 1; A = h;
    @(negedge clk);
    hi_we = 0; lo_we = 1; A = l;
    @(negedge clk);
    lo_we = 0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int ecyc,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
    int n;
    start = 1; op = o; A = a; B = b;
    @(negedge clk);
    start = 0; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, 64'(n), 64'(ecyc));
    chk({nm, "_HI"}, 64'(HI), 64'(ehi));
    chk({nm, "_LO"}, 64'(LO), 64'(elo));
  endtask

  logic [31:0] spec_v [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFF9, 32'd7};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return spec_v[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_HI", 64'(HI), 64'd0);
    chk("rst_LO", 64'(LO), 64'd0);
    reset = 0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, MC,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC,
           32'hFFFF_FFFE, 32'h0000_0001, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DC,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_op(3'd3, 32'd100, 32'd7, DC, 32'd2, 32'd14, "divu");
    mt(32'h11, 32'h22);
    run_op(3'd3, 32'd55, 32'd0, DC, 32'h11, 32'h22, "divu0");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC,
           32'd0, 32'h8000_0000, "divovf");

    // Reserved op: nothing launches.
    start = 1; op = 3'd6; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 0;
    chk("rsvd_busy", 64'(busy), 64'd0);

    // MT write plus launch on the same edge: result wins later.
    hi_we = 1; lo_we = 1;
    run_op(3'd3, 32'd9, 32'd4, DC, 32'd1, 32'd2, "mt_start");
    hi_we = 0; lo_we = 0;

    // start and lo_we during a DIV busy period are ignored.
    start = 1; op = 3'd2; A = 32'hFFFF_FFF9; B = 32'd2;
    @(negedge clk);
    start = 1; op = 3'd0; lo_we = 1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 0; lo_we = 0;
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("mid_cycles", 64'(n), 64'(DC));
    chk("mid_HI", 64'(HI), 64'hFFFF_FFFF);
    chk("mid_LO", 64'(LO), 64'hFFFF_FFFD);

    // Reset in busy cycle 3 abandons the op.
    start = 1; op = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_HI", 64'(HI), 64'd0);
    chk("rstmid_LO", 64'(LO), 64'd0);
    repeat (8) @(negedge clk);
    chk("rstmid_LO_late", 64'(LO), 64'd0);

`ifdef MDU_MADD_EN
    mt(32'd0, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd1, 32'd1, MC, 32'd1, 32'd0, "madd");
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
      hi_we = ($urandom_range(0, 9) == 0);
      lo_we = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    reset = 0; start = 0; hi_we = 0; lo_we = 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("final_idle", 64'(busy), 64'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
